// File: rtl/dma_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_stream_ctrl
// Purpose  : Stream-side DMA engine in front of the shared BRAM.
//            - WR transfer: AXI-Stream slave beats -> registered BRAM writes
//              (dma_wr_en / dma_wr_data / dma_write_pointer).
//            - RD transfer: BRAM reads (dma_rd_en / dma_read_pointer) with a
//              fixed return latency, buffered in a small FIFO that feeds the
//              AXI-Stream master so backpressure never loses data.
//            One transfer at a time; 'done' pulses for one cycle at the end.
// Ports    : clk, rst_n (async assert, active-low)
//            start_wr, start_rd, len[15:0]     command (accepted in IDLE only)
//            busy, done, len_err, xfer_count    status
//            s_axis_*                           input stream (slave)
//            m_axis_*                           output stream (master)
//            dma_wr_*, dma_rd_*, dma_*_pointer  BRAM side
// Revision : 1.0 - initial release
// ============================================================================
module dma_stream_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_wr,
  input  logic                  start_rd,
  input  logic [15:0]           len,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [15:0]           xfer_count,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  dma_wr_en,
  output logic [DATA_WIDTH-1:0] dma_wr_data,
  output logic [15:0]           dma_write_pointer,
  output logic                  dma_rd_en,
  output logic [15:0]           dma_read_pointer,
  input  logic [DATA_WIDTH-1:0] dma_rd_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t                 state, state_next;
  logic [15:0]            len_q;
  logic [15:0]            rd_issued;
  logic                   wr_last;       // final write beat accepted, strobe pending
  logic [RD_LATENCY-1:0]  issue_sr;      // one bit per read in flight
  logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]          fifo_wp, fifo_rp;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          inflight;
  logic [CW:0]            credit_sum;
  logic [15:0]            cnt_inc;
  logic                   start_accept, s_hs, m_hs, wr_final, rd_final, push;

  assign start_accept = (state == S_IDLE) && (start_wr || start_rd);
  assign s_hs         = s_axis_tvalid && s_axis_tready;
  assign m_hs         = m_axis_tvalid && m_axis_tready;
  assign cnt_inc      = xfer_count + 16'd1;
  assign wr_final     = s_hs && ((cnt_inc == len_q) || s_axis_tlast);
  assign rd_final     = m_hs && (cnt_inc == len_q);
  assign push         = issue_sr[RD_LATENCY-1];

  // Read credit: every issued-but-not-delivered word owns a FIFO slot, so the
  // FIFO cannot overflow no matter how long the output stalls.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + {{(CW-1){1'b0}}, issue_sr[i]};
    end
  end
  assign credit_sum = {1'b0, inflight} + {1'b0, fifo_count};

  // Output stream: head of FIFO; data gated so idle outputs read as zero.
  assign m_axis_tvalid = (state == S_RD) && (fifo_count != '0);
  assign m_axis_tdata  = m_axis_tvalid ? fifo_mem[fifo_rp] : '0;
  assign m_axis_tlast  = m_axis_tvalid && (xfer_count == len_q - 16'd1);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // FSM next-state and control outputs
  always_comb begin
    state_next    = state;
    s_axis_tready = 1'b0;
    dma_rd_en     = 1'b0;
    busy          = (state != S_IDLE);
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_wr)      state_next = (len == 16'd0) ? S_FIN : S_WR;
        else if (start_rd) state_next = (len == 16'd0) ? S_FIN : S_RD;
      end
      S_WR: begin
        // Stay one extra cycle after the final beat so its strobe goes out
        // before FIN; tready is already low in that cycle.
        s_axis_tready = !wr_last;
        if (wr_last) state_next = S_FIN;
      end
      S_RD: begin
        dma_rd_en = (rd_issued < len_q) && (credit_sum < DEPTH_C);
        if (rd_final) state_next = S_FIN;
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Transfer bookkeeping and registered write strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q             <= '0;
      xfer_count        <= '0;
      len_err           <= 1'b0;
      wr_last           <= 1'b0;
      rd_issued         <= '0;
      dma_wr_en         <= 1'b0;
      dma_wr_data       <= '0;
      dma_write_pointer <= '0;
    end else begin
      dma_wr_en <= s_hs;
      if (s_hs) begin
        dma_wr_data       <= s_axis_tdata;
        dma_write_pointer <= xfer_count;
      end
      if (start_accept) begin
        len_q      <= len;
        xfer_count <= '0;
        len_err    <= 1'b0;
        wr_last    <= 1'b0;
        rd_issued  <= '0;
      end else begin
        if (s_hs) begin
          xfer_count <= cnt_inc;
          if (wr_final) wr_last <= 1'b1;
          if (s_axis_tlast && (cnt_inc < len_q)) len_err <= 1'b1;
        end
        if (m_hs)      xfer_count <= cnt_inc;
        if (dma_rd_en) rd_issued  <= rd_issued + 16'd1;
      end
    end
  end

  assign dma_read_pointer = rd_issued;

  // Read-latency pipeline and return FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_sr   <= '0;
      fifo_wp    <= '0;
      fifo_rp    <= '0;
      fifo_count <= '0;
    end else begin
      for (int i = RD_LATENCY - 1; i > 0; i--) begin
        issue_sr[i] <= issue_sr[i-1];
      end
      issue_sr[0] <= dma_rd_en;
      if (push) fifo_wp <= fifo_wp + 1'b1;
      if (m_hs) fifo_rp <= fifo_rp + 1'b1;
      case ({push, m_hs})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage (no reset needed: contents are only read while counted valid)
  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wp] <= dma_rd_data;
  end

endmodule
`default_nettype wire

// File: doc/dma_stream_ctrl.md
# dma_stream_ctrl

Stream-side DMA engine in front of the accelerator's shared BRAM. It converts an AXI-Stream slave input into word-indexed BRAM write strobes (`dma_wr_en`, `dma_write_pointer`) and converts BRAM read strobes (`dma_rd_en`, `dma_read_pointer`) into an AXI-Stream master output. Read data returns after a fixed latency and is buffered in a small FIFO so the output stream honours backpressure. A command port starts one transfer at a time, and a `done` pulse signals completion to the host-side control FSM.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width, on both streams and on the BRAM side.
- `RD_LATENCY`, 2: cycles from `dma_rd_en` high to valid `dma_rd_data`.
- `FIFO_DEPTH`, 4: read-return FIFO entries. Must be a power of two and at least `RD_LATENCY+1`.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock for the whole block.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `start_wr`, in, 1: one-cycle request to run a stream-to-BRAM transfer.
- `start_rd`, in, 1: one-cycle request to run a BRAM-to-stream transfer.
- `len`, in, 16: transfer length in words, sampled on an accepted start.
- `busy`, out, 1: high while a transfer is in progress.
- `done`, out, 1: one-cycle pulse at the end of a transfer.
- `len_err`, out, 1: high when the last write ended on `tlast` before reaching `len`. Held until the next accepted start.
- `xfer_count`, out, 16: number of words completed in the current or last transfer.
- `s_axis_tdata`, in, DATA_WIDTH: input stream data.
- `s_axis_tvalid`, in, 1: input stream valid.
- `s_axis_tlast`, in, 1: input stream last-word marker.
- `s_axis_tready`, out, 1: input stream ready.
- `m_axis_tdata`, out, DATA_WIDTH: output stream data.
- `m_axis_tvalid`, out, 1: output stream valid.
- `m_axis_tlast`, out, 1: output stream last-word marker.
- `m_axis_tready`, in, 1: output stream ready.
- `dma_wr_en`, out, 1: BRAM write strobe.
- `dma_wr_data`, out, DATA_WIDTH: BRAM write data.
- `dma_write_pointer`, out, 16: word offset for the write.
- `dma_rd_en`, out, 1: BRAM read strobe.
- `dma_read_pointer`, out, 16: word offset for the read.
- `dma_rd_data`, in, DATA_WIDTH: BRAM read data.

## Operation
- States:
  - IDLE.
  - WR: stream-to-BRAM.
  - RD: BRAM-to-stream.
  - FIN: emits `done`, then returns to IDLE.
- Start handling:
  - A start is accepted only in IDLE. Starts seen in any other state are ignored.
  - If `start_wr` and `start_rd` are high together, the write wins and the read is dropped.
  - On an accepted start: latch `len`, clear `xfer_count`, clear `len_err`.
  - If `len==0`: go directly to FIN. No beats are transferred and no strobes are issued.
- WR state:
  - `s_axis_tready=1`.
  - Each handshake registers one BRAM write with `dma_write_pointer` = current `xfer_count`, then increments `xfer_count`.
  - The transfer ends at the handshake where `xfer_count+1==len`, or at a handshake with `tlast=1`, whichever comes first.
  - If it ends on `tlast` with `xfer_count+1<len`, set `len_err`.
  - A `tlast` that arrives exactly at `len` is not an error.
- RD state:
  - Issue counter `rd_issued` runs from 0 to `len-1` and drives `dma_read_pointer`.
  - Issue `dma_rd_en` only when `rd_issued<len` and `inflight + fifo_count < FIFO_DEPTH`.
  - `inflight` is tracked by a RD_LATENCY-deep shift register of issue bits.
  - When the tail bit of the shift register is 1, push `dma_rd_data` into the FIFO.
  - The FIFO head drives the M_AXIS outputs.
  - Assert `m_axis_tlast` on the word with index `len-1`.
  - Each M_AXIS handshake increments `xfer_count`.
  - The read ends when the last word has handshaken.
- `dma_wr_en` and `dma_rd_en` are never high in the same cycle.

## Timing
- Reset values: all outputs 0, including `s_axis_tready` and `m_axis_tvalid`. The FIFO is empty and all counters are 0.
- Asserting reset mid-transfer aborts it immediately. No `done` pulse is produced and the FIFO is flushed.
- Start to active: a start accepted at cycle t puts the block in WR or RD at t+1, with `busy=1` from t+1.
- Write path:
  - An S_AXIS handshake at cycle t produces `dma_wr_en=1` at t+1, with the registered data and pointer.
  - Sustained throughput is 1 word per cycle.
- Read path:
  - `dma_rd_en` at cycle t means data is captured at t+RD_LATENCY.
  - The earliest `m_axis_tvalid` is t+RD_LATENCY+1.
  - With `m_axis_tready` held high, throughput is 1 word per cycle after the initial latency.
  - A stall never loses data, because the credit check prevents FIFO overflow.
- AXIS rules:
  - `m_axis_tvalid`, `m_axis_tdata` and `m_axis_tlast` stay stable until the handshake.
  - `s_axis_tready` falls in the cycle after the final handshake.
- Completion:
  - FIN lasts 1 cycle, with `done=1` and `busy=1`.
  - Return to IDLE follows, with `busy=0`.
  - For writes, FIN comes the cycle after the last `dma_wr_en`.
- Pointers and counts wrap modulo 2^16. `len` is at most 65535, so pointers never actually wrap within one transfer.

## Test plan
- Write, `len=4`, S_AXIS words 0xA0..0xA3 with `tlast` on the fourth:
  - `dma_wr_en` high on 4 consecutive cycles, with pointers 0,1,2,3 and matching data.
  - `done` pulses once, `len_err=0`, `xfer_count=4`.
- Write, `len=8`, `tlast` on the third word:
  - Exactly 3 writes to pointers 0..2.
  - `len_err=1`, `xfer_count=3`, `done` pulses.
- Read, `len=6`, BRAM model with latency 2 returning 0x100+ptr, `m_axis_tready` toggling randomly:
  - Output is 0x100..0x105 in order with no drops or duplicates.
  - `tlast` only on 0x105, and the FIFO never exceeds 4 entries.
- Read, `len=5`, `m_axis_tready=0` for 20 cycles then held high:
  - `dma_rd_en` issues exactly 4 reads and then stalls.
  - All 5 words are delivered after the release.
- Start handling:
  - `start_wr` and `start_rd` together with `len=2`: only a write transfer runs.
  - `start_rd` while busy: ignored.
  - `len=0`: `done` one cycle after the start, with no strobes.
- Reset mid-read:
  - `rst_n` low after the second output word: all outputs 0 within the same cycle and no `done`.
  - A following read with `len=3` completes normally.
